adc_capture_packer: RTL and testbench
=====================================

// Module: adc_capture_packer
// PURPOSE
//  Downstream stage of the ADC front-end block: takes its valid-qualified sample stream and packs
//  PACK_N samples into one wide word. Captures a programmed number of words after arm + trigger,
//  delivers them on a valid/ready port to the capture buffer, flags drops.
// PARAMETERS
//  ADC_W   12  sample width in bits
//  PACK_N  4   samples per output word (>=2)
//  CNT_W   16  width of word counter / capture length
// PORTS
//  clk          in   1              single clock; all logic on rising edge
//  rst_n        in   1              asynchronous active-low reset
//  arm_i        in   1              pulse: latch cap_len_i, IDLE/DONE -> ARMED
//  trig_i       in   1              level/pulse: ARMED -> CAPTURE
//  clr_i        in   1              sync abort: any state -> IDLE, flush, clear ovf_o
//  cap_len_i    in   CNT_W          words per capture; 0 = arm ignored
//  smp_valid_i  in   1              sample strobe (no backpressure upstream)
//  smp_data_i   in   ADC_W          sample value
//  out_valid_o  out  1              output word valid
//  out_ready_i  in   1              downstream accepts when valid&&ready
//  out_data_o   out  PACK_N*ADC_W   packed word; first sample in LSBs
//  out_last_o   out  1              marks final word of capture
//  busy_o       out  1              state in ARMED/CAPTURE/DRAIN
//  done_o       out  1              state == DONE
//  ovf_o        out  1              sticky: >=1 sample dropped
// BEHAVIOUR
//  Reset: state IDLE; all outputs, lane index, word count, pack/out registers = 0.
//  FSM IDLE->ARMED (arm_i && cap_len_i!=0); ARMED->CAPTURE (trig_i); CAPTURE->DRAIN
//   (word #cap_len moved to out reg); DRAIN->DONE (last word handshaken);
//   DONE->ARMED (arm_i, same rule) ; clr_i wins over every transition -> IDLE.
//  arm_i outside IDLE/DONE ignored. trig_i outside ARMED ignored.
//  Sample accepted in the trig_i cycle if smp_valid_i=1 (first sample = lane 0).
//  CAPTURE: each accepted sample written at lane idx*ADC_W, idx++; idx==PACK_N-1 write
//   completes pack reg (pack_full=1), idx wraps to 0.
//  Pack->out transfer when pack_full && (!out_valid_o || out_ready_i); same-cycle drain
//   and refill allowed. Word count increments on transfer; out_last_o=1 when count==cap_len.
//  Latency: PACK_N-th sample at edge t -> out_valid_o=1 after edge t+1 (out reg free).
//  Drop: smp_valid_i while pack_full and no transfer that cycle -> sample discarded,
//   ovf_o<=1, idx unchanged. Samples in DRAIN/DONE/IDLE/ARMED(no trig) ignored, no ovf.
//  out_valid_o held, out_data_o/out_last_o stable until handshake.
//  Partial word at clr_i discarded; out_valid_o drops next cycle.
//  Counter width: cap_len up to 2^CNT_W-1, no wrap within a capture.
//  rst_n low mid-capture: immediate async clear, no word emitted.
// STRUCTURE
//  Package adc_capture_pkg: state enum {IDLE,ARMED,CAPTURE,DRAIN,DONE}, default ADC_W,
//   PACK_N, CNT_W constants, packed-word width function.
//  Sub-module adc_capture_outreg: 1-entry valid/ready holding register (data+last).
//  Top: FSM, lane index, pack register, word counter, ovf flag.
// TESTING
//  ADC_W=12,PACK_N=4: arm(len=2),trig, 8 samples 0x001..0x008, ready=1 -> words
//   0x004003002001, 0x008007006005(last); done_o=1; ovf_o=0.
//  Same, ready=0 for 12 cycles: 12 samples -> 2nd word waits in pack reg, 9th sample
//   dropped, ovf_o=1; words still 0x004003002001 then 0x008007006005.
//  arm with cap_len=0 -> state stays IDLE, busy_o=0.
//  clr_i after 3 samples of word 1 -> IDLE next cycle, no out_valid_o, ovf_o=0.
//  rst_n low during CAPTURE with out_valid_o=1 -> all outputs 0 immediately (async).
//  Back-to-back: ready=1, smp_valid every cycle, len=3 -> 3 words, no drops, DONE.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture packer: FSM states,
// default geometry and the packed-word width helper.
package adc_capture_pkg;

  localparam int ADC_W_DEF  = 12;
  localparam int PACK_N_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic int packed_w(input int adc_w, input int pack_n);
    return adc_w * pack_n;
  endfunction

endpackage

// File: rtl/adc_capture_packer_if.sv
// Output word stream towards the capture buffer.
// Handshake: a word moves when out_valid_o && out_ready_i on a rising edge; once
// raised, out_valid_o stays high and out_data_o/out_last_o stay stable until then.
interface adc_capture_packer_if
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = packed_w(ADC_W_DEF, PACK_N_DEF)
) ();

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;

  modport master (output out_valid_o, out_data_o, out_last_o, input out_ready_i);
  modport slave  (input out_valid_o, out_data_o, out_last_o, output out_ready_i);

endinterface

// File: rtl/adc_capture_outreg.sv
// One-entry valid/ready holding register for packed words plus their last flag.
// The parent only asserts load_i when free_o is high.
module adc_capture_outreg #(
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic              free_o,
  adc_capture_packer_if.master out_if
);

  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (valid_q && out_if.out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Free this cycle if empty or the held word is being taken right now.
  assign free_o             = !valid_q || out_if.out_ready_i;
  assign out_if.out_valid_o = valid_q;
  assign out_if.out_data_o  = data_q;
  assign out_if.out_last_o  = last_q;

endmodule

// File: rtl/adc_capture_packer.sv
// Arm/trigger controlled sample packer: groups PACK_N samples per word, emits
// cap_len words on a valid/ready port and flags samples dropped under backpressure.
module adc_capture_packer
  import adc_capture_pkg::*;
#(
  parameter int ADC_W  = ADC_W_DEF,
  parameter int PACK_N = PACK_N_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] cap_len_i,
  input  logic             smp_valid_i,
  input  logic [ADC_W-1:0] smp_data_i,
  adc_capture_packer_if.master out_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output state_t           dbg_state_o
);

  localparam int PW    = packed_w(ADC_W, PACK_N);
  localparam int IDX_W = $clog2(PACK_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    pack_q, pack_d;
  logic             pack_full_q, pack_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic             ovf_q, ovf_d, busy_q, done_q;
  logic             out_free, xfer, xfer_last, in_window, smp_take, smp_drop, arm_ok;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    arm_ok    = arm_i && (cap_len_i != '0);
    in_window = (state_q == CAPTURE) || ((state_q == ARMED) && trig_i);
    xfer      = (state_q == CAPTURE) && pack_full_q && out_free;
    xfer_last = xfer && (cnt_inc == len_q);
    // A sample arriving alongside the final word's transfer belongs to no word.
    smp_take  = smp_valid_i && in_window && (!pack_full_q || (xfer && !xfer_last));
    smp_drop  = smp_valid_i && (state_q == CAPTURE) && pack_full_q && !xfer;

    state_d     = state_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    pack_full_d = pack_full_q && !xfer;
    cnt_d       = xfer ? cnt_inc : cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q || smp_drop;

    if (smp_take) begin
      for (int l = 0; l < PACK_N; l++) begin
        if (idx_q == IDX_W'(l)) pack_d[l*ADC_W +: ADC_W] = smp_data_i;
      end
      if (idx_q == LAST_IDX) begin
        idx_d       = '0;
        pack_full_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (arm_ok) begin
          state_d     = ARMED;
          len_d       = cap_len_i;
          cnt_d       = '0;
          idx_d       = '0;
          pack_full_d = 1'b0;
        end
      end
      ARMED:   if (trig_i) state_d = CAPTURE;
      CAPTURE: if (xfer_last) state_d = DRAIN;
      DRAIN:   if (out_if.out_valid_o && out_if.out_ready_i) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      state_d     = IDLE;
      idx_d       = '0;
      pack_d      = '0;
      pack_full_d = 1'b0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pack_q      <= '0;
      pack_full_q <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      pack_full_q <= pack_full_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d == ARMED) || (state_d == CAPTURE) || (state_d == DRAIN);
      done_q      <= (state_d == DONE);
    end
  end

  adc_capture_outreg #(.DATA_W(PW)) u_outreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_i),
    .load_i (xfer),
    .data_i (pack_q),
    .last_i (xfer_last),
    .free_o (out_free),
    .out_if (out_if)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_capture_packer.sv
// Directed bench for adc_capture_packer: expected words come from an arithmetic
// packing model and are checked by a per-cycle compare process.
module tb_adc_capture_packer;
  import adc_capture_pkg::*;

  localparam int ADC_W  = 12;
  localparam int PACK_N = 4;
  localparam int CNT_W  = 16;
  localparam int PW     = ADC_W * PACK_N;
  localparam int W      = PW + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm_i = 1'b0;
  logic             trig_i = 1'b0;
  logic             clr_i = 1'b0;
  logic [CNT_W-1:0] cap_len_i = '0;
  logic             smp_valid_i = 1'b0;
  logic [ADC_W-1:0] smp_data_i = '0;
  logic             busy_o, done_o, ovf_o;
  state_t           dbg_state_o;

  adc_capture_packer_if #(.DATA_W(PW)) out_if ();

  adc_capture_packer #(.ADC_W(ADC_W), .PACK_N(PACK_N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm_i       (arm_i),
    .trig_i      (trig_i),
    .clr_i       (clr_i),
    .cap_len_i   (cap_len_i),
    .smp_valid_i (smp_valid_i),
    .smp_data_i  (smp_data_i),
    .out_if      (out_if),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: sample k of a capture has value first_val+k; word w holds samples
  // w*PACK_N .. w*PACK_N+PACK_N-1 with the earliest in the low bits
  task automatic expect_words(input int first_val, input int len);
    logic [PW-1:0] word;
    for (int w = 0; w < len; w++) begin
      word = '0;
      for (int l = 0; l < PACK_N; l++)
        word = word + (PW'(first_val + w*PACK_N + l) << (l*ADC_W));
      exp_q.push_back({(w == len-1), word});
    end
  endtask

  // driver tasks
  task automatic arm(input int len);
    arm_i = 1'b1;
    cap_len_i = CNT_W'(len);
    tick();
    arm_i = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic stop_samples();
    trig_i = 1'b0;
    smp_valid_i = 1'b0;
  endtask

  task automatic send(input int k, input int val);
    trig_i = (k == 1);
    smp_valid_i = 1'b1;
    smp_data_i = ADC_W'(val);
    tick();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 64'(done_o), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_if.out_valid_o), 64'(0));
    chk({tag, "_data"},  64'(out_if.out_data_o), 64'(0));
    chk({tag, "_last"},  64'(out_if.out_last_o), 64'(0));
    chk({tag, "_busy"},  64'(busy_o), 64'(0));
    chk({tag, "_done"},  64'(done_o), 64'(0));
    chk({tag, "_ovf"},   64'(ovf_o), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state_o), 64'(IDLE));
  endtask

  // scoreboard / compare process
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_val = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 64'(out_if.out_valid_o), 64'(1));
        chk("hold_word", 64'({out_if.out_last_o, out_if.out_data_o}), 64'(hold_val));
      end
      if (out_if.out_valid_o && out_if.out_ready_i) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none",
                   {out_if.out_last_o, out_if.out_data_o});
        end else begin
          chk("out_word", 64'({out_if.out_last_o, out_if.out_data_o}), 64'(exp_q.pop_front()));
        end
      end
      hold_pending = out_if.out_valid_o && !out_if.out_ready_i && !clr_i;
      hold_val = {out_if.out_last_o, out_if.out_data_o};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ws0;
    out_if.out_ready_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // 1: len=2, ready=1, 8 samples
    out_if.out_ready_i = 1'b1;
    arm(2);
    chk("t1_armed", 64'(dbg_state_o), 64'(ARMED));
    chk("t1_busy", 64'(busy_o), 64'(1));
    expect_words(1, 2);
    chk("t1_model_w0", 64'(exp_q[0]), 64'({1'b0, 48'h004003002001}));
    chk("t1_model_w1", 64'(exp_q[1]), 64'({1'b1, 48'h008007006005}));
    for (int k = 1; k <= 8; k++) begin
      send(k, k);
      if (k == 4) chk("t1_lat_before", 64'(out_if.out_valid_o), 64'(0));
      if (k == 5) chk("t1_lat_after", 64'(out_if.out_valid_o), 64'(1));
    end
    stop_samples();
    wait_done(40);
    chk("t1_busy_end", 64'(busy_o), 64'(0));
    chk("t1_ovf", 64'(ovf_o), 64'(0));
    chk("t1_exp_empty", 64'(exp_q.size()), 64'(0));
    chk("t1_words", 64'(words_seen), 64'(2));

    // 2: len=2, ready=0 during 12 samples -> samples 9..12 dropped
    clr_pulse();
    out_if.out_ready_i = 1'b0;
    arm(2);
    expect_words(1, 2);
    for (int k = 1; k <= 12; k++) send(k, k);
    stop_samples();
    chk("t2_ovf", 64'(ovf_o), 64'(1));
    chk("t2_valid", 64'(out_if.out_valid_o), 64'(1));
    chk("t2_held_w0", 64'(out_if.out_data_o), 64'(48'h004003002001));
    chk("t2_state", 64'(dbg_state_o), 64'(CAPTURE));
    out_if.out_ready_i = 1'b1;
    wait_done(40);
    chk("t2_ovf_sticky", 64'(ovf_o), 64'(1));
    chk("t2_exp_empty", 64'(exp_q.size()), 64'(0));
    chk("t2_words", 64'(words_seen), 64'(4));
    clr_pulse();
    chk("t2_clr_state", 64'(dbg_state_o), 64'(IDLE));
    chk("t2_clr_ovf", 64'(ovf_o), 64'(0));
    chk("t2_clr_done", 64'(done_o), 64'(0));

    // 3: arm with cap_len=0 is ignored
    arm(0);
    chk("t3_state", 64'(dbg_state_o), 64'(IDLE));
    chk("t3_busy", 64'(busy_o), 64'(0));

    // 4: clr after 3 samples of the first word
    ws0 = words_seen;
    arm(1);
    for (int k = 1; k <= 3; k++) send(k, 12'h0a0 + k);
    stop_samples();
    clr_pulse();
    chk("t4_state", 64'(dbg_state_o), 64'(IDLE));
    chk("t4_busy", 64'(busy_o), 64'(0));
    chk("t4_valid", 64'(out_if.out_valid_o), 64'(0));
    chk("t4_ovf", 64'(ovf_o), 64'(0));
    for (int k = 1; k <= 6; k++) begin
      smp_valid_i = 1'b1;
      smp_data_i = ADC_W'(k);
      tick();
    end
    stop_samples();
    chk("t4_idle_valid", 64'(out_if.out_valid_o), 64'(0));
    chk("t4_idle_ovf", 64'(ovf_o), 64'(0));
    chk("t4_words", 64'(words_seen - ws0), 64'(0));

    // 5: async reset while a word is pending
    out_if.out_ready_i = 1'b0;
    arm(2);
    expect_words(1, 2);
    for (int k = 1; k <= 5; k++) send(k, k);
    stop_samples();
    chk("t5_valid_pre", 64'(out_if.out_valid_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 6: back-to-back, len=3
    ws0 = words_seen;
    out_if.out_ready_i = 1'b1;
    arm(3);
    expect_words(12'h101, 3);
    chk("t6_model_w0", 64'(exp_q[0]), 64'({1'b0, 48'h104103102101}));
    chk("t6_model_w2", 64'(exp_q[2]), 64'({1'b1, 48'h10c10b10a109}));
    for (int k = 1; k <= 12; k++) send(k, 12'h100 + k);
    stop_samples();
    wait_done(40);
    chk("t6_state", 64'(dbg_state_o), 64'(DONE));
    chk("t6_ovf", 64'(ovf_o), 64'(0));
    chk("t6_exp_empty", 64'(exp_q.size()), 64'(0));
    chk("t6_words", 64'(words_seen - ws0), 64'(3));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
